layer4_pipeline_feeder: RTL and testbench
=========================================

Name: layer4_pipeline_feeder

Overview:
Front-end sequencer for the layer-4 adder-tree/bias/ReLU pipeline. Packs a serial stream of DATA_WIDTH-bit products into a 16-lane vector and launches it with a one-cycle o_valid_in_bias strobe. Generates the per-stage enable vector o_valid_pipeline[4:0] that steps the launched vector through the five downstream register stages. Flags o_result_valid in the cycle the pipeline output word is valid.

Parameters:
DATA_WIDTH, 32, width of each lane word (IEEE-754 single in current use)
LANES, 16, words per launched vector; fixed at 16 to match the adder tree
STAGES, 5, number of downstream enables after o_valid_in_bias

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
i_data  input  DATA_WIDTH  incoming product word
i_valid  input  1  i_data is valid this cycle
i_last  input  1  qualifies i_data as the last word of a partial vector; only meaningful with i_valid
o_ready  output  1  feeder accepts a word this cycle; a word transfers when i_valid && o_ready
o_vector  output  DATA_WIDTH*LANES  packed vector; lane k occupies bits [DATA_WIDTH*(k+1)-1 : DATA_WIDTH*k]
o_valid_in_bias  output  1  one-cycle launch strobe; o_vector is valid in this cycle
o_valid_pipeline  output  STAGES  bit k = o_valid_in_bias delayed k+1 cycles
o_result_valid  output  1  o_valid_in_bias delayed STAGES+1 cycles; pipeline output valid
o_busy  output  1  partial vector held, or any launch/stage/result bit set

Behaviour:
- Reset (async, immediate): lane counter=0, collector=0, o_vector=0, o_valid_in_bias=0, o_valid_pipeline=0, o_result_valid=0, o_busy=0, o_ready=0 while rst is high.
- o_ready=1 in every cycle after reset deasserts. The downstream pipeline never stalls, so the feeder applies no back-pressure.
- The lane counter cnt runs 0..15. The collector register holds lanes 0..cnt-1.
- States: EMPTY (cnt==0) and FILL (cnt 1..15). There is no separate launch state; launch is a registered pulse.
- Accepted word in any state with cnt<15 and !i_last: collector lane cnt <= i_data, and cnt increments.
- Accepted word with cnt==15, or with i_last at any cnt:
  - Next edge: o_vector <= collector with lane cnt = i_data. Lanes above cnt are forced to 0 (zero padding, +0.0).
  - Same edge: o_valid_in_bias <= 1 for exactly one cycle, collector <= 0, cnt <= 0.
- Back-to-back launches are legal. A launch cycle and the first word of the next vector may coincide; that word lands in collector lane 0 and is not in the launched o_vector.
- o_vector holds its value between launches; it changes only on launch or reset.
- Enable timing: shift register of depth STAGES+1 fed by o_valid_in_bias.
  - Launch strobe in cycle c → o_valid_pipeline[k] high in cycle c+1+k, o_result_valid high in cycle c+6.
  - Each bit is high for one cycle per launch. Consecutive launches produce overlapping independent bits.
- i_valid low: no state change other than the shift register advancing.
- i_last with cnt==15 behaves as a normal full launch (no padding).
- rst mid-fill or mid-flight: the partial vector and all in-flight strobes are discarded; no o_result_valid occurs for them.
- o_busy = (cnt!=0) | o_valid_in_bias | |o_valid_pipeline | o_result_valid.

Test Plan:
- Reset, then 16 words 1..16 (as 32'h3F800000 etc.) on consecutive cycles with i_valid=1 → one o_valid_in_bias pulse the cycle after word 16; lane 0=word 1, lane 15=word 16; o_valid_pipeline[0..4] each high once in cycles +1..+5; o_result_valid high at +6; o_busy low afterwards.
- 48 words streamed continuously → three launches exactly 16 cycles apart; no word dropped or duplicated; o_result_valid pulses 16 cycles apart.
- 5 words with i_last on word 5 → launch next cycle; lanes 0..4 = data, lanes 5..15 = 32'h0; cnt returns to 0; the next word goes to lane 0.
- i_valid toggled randomly (50%) over 32 words → launches only after every 16th accepted word; lane order preserved.
- rst asserted asynchronously after 7 words, and again 2 cycles after a launch → all outputs 0 immediately; no o_result_valid for the aborted vector; fresh 16-word fill afterwards launches normally.
- i_last asserted on word 16 → identical result to a normal full launch; only one strobe.

Source files
------------

// File: rtl/layer4_pipeline_feeder.sv
// rtl/layer4_pipeline_feeder.sv - serial-to-vector packer and stage-enable sequencer for the layer-4 pipeline
//
// Purpose:
//   Collects DATA_WIDTH-bit words into a LANES-wide vector. The vector launches with a
//   one-cycle o_valid_in_bias strobe. The launch happens when the last lane fills or when
//   i_last marks a short vector; unused lanes are zero-padded. The strobe is then walked
//   through a STAGES+1 deep shift register. That register produces the per-stage enables
//   and the final result-valid flag.
//
// Ports:
//   clk              - rising-edge clock
//   rst              - asynchronous active-high reset
//   i_data           - incoming word
//   i_valid          - i_data valid this cycle
//   i_last           - marks the final word of a partial vector (qualified by i_valid)
//   o_ready          - feeder can accept a word (low only while/just after reset)
//   o_vector         - launched vector, lane k at bits [DATA_WIDTH*(k+1)-1 : DATA_WIDTH*k]
//   o_valid_in_bias  - one-cycle launch strobe
//   o_valid_pipeline - bit k is the launch strobe delayed k+1 cycles
//   o_result_valid   - launch strobe delayed STAGES+1 cycles
//   o_busy           - partial vector held or any strobe in flight

module layer4_pipeline_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 16,
  parameter int STAGES     = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         i_data,
  input  logic                          i_valid,
  input  logic                          i_last,
  output logic                          o_ready,
  output logic [DATA_WIDTH*LANES-1:0]   o_vector,
  output logic                          o_valid_in_bias,
  output logic [STAGES-1:0]             o_valid_pipeline,
  output logic                          o_result_valid,
  output logic                          o_busy
);

  localparam int CW = $clog2(LANES);
  localparam logic [CW-1:0] LAST_LANE = CW'(LANES - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    FILL  = 1'b1
  } state_t;

  state_t                        state_q, state_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [DATA_WIDTH*LANES-1:0]   coll_q, coll_d;
  logic [DATA_WIDTH*LANES-1:0]   vec_q, vec_d;
  logic                          vib_q, vib_d;
  logic                          ready_q, ready_d;
  // shift_q[STAGES-1:0] are the stage enables, shift_q[STAGES] is result-valid
  logic [STAGES:0]               shift_q, shift_d;
  logic                          accept;
  logic                          launch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
      coll_q  <= '0;
      vec_q   <= '0;
      vib_q   <= 1'b0;
      ready_q <= 1'b0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      coll_q  <= coll_d;
      vec_q   <= vec_d;
      vib_q   <= vib_d;
      ready_q <= ready_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    coll_d  = coll_q;
    vec_d   = vec_q;
    vib_d   = 1'b0;
    ready_d = 1'b1;
    shift_d = {shift_q[STAGES-1:0], vib_q};
    accept  = i_valid & ready_q;
    launch  = accept & (i_last | (cnt_q == LAST_LANE));

    if (launch) begin
      // Assemble the vector directly from the collector plus the word arriving now.
      // Lanes above the current one are padded with +0.0.
      for (int k = 0; k < LANES; k++) begin
        if (CW'(k) < cnt_q) begin
          vec_d[k*DATA_WIDTH +: DATA_WIDTH] = coll_q[k*DATA_WIDTH +: DATA_WIDTH];
        end else if (CW'(k) == cnt_q) begin
          vec_d[k*DATA_WIDTH +: DATA_WIDTH] = i_data;
        end else begin
          vec_d[k*DATA_WIDTH +: DATA_WIDTH] = '0;
        end
      end
      vib_d   = 1'b1;
      coll_d  = '0;
      cnt_d   = '0;
      state_d = EMPTY;
    end else if (accept) begin
      for (int k = 0; k < LANES; k++) begin
        if (CW'(k) == cnt_q) begin
          coll_d[k*DATA_WIDTH +: DATA_WIDTH] = i_data;
        end
      end
      cnt_d   = cnt_q + CW'(1);
      state_d = FILL;
    end
  end

  assign o_ready          = ready_q;
  assign o_vector         = vec_q;
  assign o_valid_in_bias  = vib_q;
  assign o_valid_pipeline = shift_q[STAGES-1:0];
  assign o_result_valid   = shift_q[STAGES];
  assign o_busy           = (state_q == FILL) | vib_q | (|shift_q);

endmodule

// File: tb/tb_layer4_pipeline_feeder.sv
// tb/tb_layer4_pipeline_feeder.sv - randomized self-checking bench for layer4_pipeline_feeder

module tb_layer4_pipeline_feeder;

  localparam int DW = 32;
  localparam int L  = 16;
  localparam int S  = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [DW-1:0]     i_data = '0;
  logic              i_valid = 1'b0;
  logic              i_last = 1'b0;
  logic              o_ready;
  logic [DW*L-1:0]   o_vector;
  logic              o_valid_in_bias;
  logic [S-1:0]      o_valid_pipeline;
  logic              o_result_valid;
  logic              o_busy;

  layer4_pipeline_feeder #(
    .DATA_WIDTH(DW),
    .LANES(L),
    .STAGES(S)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_data(i_data),
    .i_valid(i_valid),
    .i_last(i_last),
    .o_ready(o_ready),
    .o_vector(o_vector),
    .o_valid_in_bias(o_valid_in_bias),
    .o_valid_pipeline(o_valid_pipeline),
    .o_result_valid(o_result_valid),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: words of the vector being built, launch history by cycle
  logic [DW-1:0]   cur[$];
  logic [DW*L-1:0] exp_vec = '0;
  bit              launch_at[int];
  int              cyc = 0;
  bit              exp_ready = 1'b0;
  int              dut_launches = 0;
  int              dut_results = 0;

  task automatic check(input string tag, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
  endtask

  function automatic bit launched(input int c);
    return launch_at.exists(c);
  endfunction

  function automatic logic [31:0] f32_of_int(input int n);
    int e = 0;
    while ((n >> (e + 1)) != 0) e++;
    return {1'b0, 8'(127 + e), 23'((n - (1 << e)) << (23 - e))};
  endfunction

  task automatic check_outputs();
    logic [S-1:0] exp_pipe;
    bit exp_busy;
    exp_busy = (cur.size() != 0) || launched(cyc) || launched(cyc - S - 1);
    for (int k = 0; k < S; k++) begin
      exp_pipe[k] = launched(cyc - 1 - k);
      if (exp_pipe[k]) exp_busy = 1'b1;
    end
    if (o_valid_in_bias === 1'b1) dut_launches++;
    if (o_result_valid === 1'b1) dut_results++;
    check("ready", 512'(o_ready), 512'(exp_ready));
    check("valid_in_bias", 512'(o_valid_in_bias), 512'(launched(cyc)));
    check("valid_pipeline", 512'(o_valid_pipeline), 512'(exp_pipe));
    check("result_valid", 512'(o_result_valid), 512'(launched(cyc - S - 1)));
    check("busy", 512'(o_busy), 512'(exp_busy));
    check("vector", o_vector, exp_vec);
  endtask

  task automatic step(input bit v, input logic [DW-1:0] d, input bit l);
    i_valid = v;
    i_data  = d;
    i_last  = l;
    @(posedge clk);
    cyc++;
    if (!rst && v && exp_ready) begin
      cur.push_back(d);
      if (l || cur.size() == L) begin
        exp_vec = '0;
        foreach (cur[i]) exp_vec[i*DW +: DW] = cur[i];
        launch_at[cyc] = 1'b1;
        cur.delete();
      end
    end
    exp_ready = !rst;
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b1;
    i_valid = 1'b0;
    i_last = 1'b0;
    #1;
    cur.delete();
    launch_at.delete();
    exp_vec = '0;
    exp_ready = 1'b0;
    check_outputs();
    idle(2);
    rst = 1'b0;
    idle(1);
  endtask

  initial begin
    int acc;
    int l0;
    int r0;
    #1 rst = 1'b1;
    #1 check_outputs();
    idle(2);
    rst = 1'b0;
    idle(2);

    // 16 float words 1.0 .. 16.0
    for (int n = 1; n <= L; n++) step(1'b1, f32_of_int(n), 1'b0);
    check("lane0_is_1.0", 512'(o_vector[31:0]), 512'(32'h3F80_0000));
    check("lane15_is_16.0", 512'(o_vector[511:480]), 512'(32'h4180_0000));
    idle(8);

    // 48 words streamed back to back
    l0 = dut_launches;
    r0 = dut_results;
    for (int n = 0; n < 3 * L; n++) step(1'b1, $urandom, 1'b0);
    idle(8);
    check("stream_launches", 512'(dut_launches - l0), 512'(3));
    check("stream_results", 512'(dut_results - r0), 512'(3));

    // short vector of 5 words, then the next word must start at lane 0
    for (int n = 0; n < 5; n++) step(1'b1, $urandom, n == 4);
    check("pad_lanes_zero", 512'(o_vector[511:160]), 512'(0));
    for (int n = 0; n < L; n++) step(1'b1, 32'hA000_0000 + 32'(n), 1'b0);
    check("refill_lane0", 512'(o_vector[31:0]), 512'(32'hA000_0000));
    idle(8);

    // 32 accepted words with i_valid toggled randomly
    acc = 0;
    while (acc < 2 * L) begin
      bit v;
      v = 1'($urandom_range(0, 1));
      step(v, $urandom, 1'b0);
      if (v) acc++;
    end
    idle(8);

    // reset part-way through a fill
    for (int n = 0; n < 7; n++) step(1'b1, $urandom, 1'b0);
    async_reset();
    idle(8);

    // full fill, then reset two cycles after the launch
    for (int n = 0; n < L; n++) step(1'b1, $urandom, 1'b0);
    idle(2);
    async_reset();
    r0 = dut_results;
    idle(8);
    check("no_result_after_abort", 512'(dut_results - r0), 512'(0));

    // fresh fill after reset
    for (int n = 0; n < L; n++) step(1'b1, $urandom, 1'b0);
    idle(8);

    // i_last on word 16 equals a plain full launch
    l0 = dut_launches;
    for (int n = 0; n < L; n++) step(1'b1, $urandom, n == L - 1);
    idle(8);
    check("last_on_16_one_strobe", 512'(dut_launches - l0), 512'(1));

    // random valid and random i_last
    for (int n = 0; n < 80; n++) step(1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 7) == 0);
    idle(8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
